// File: rtl/ysyx_25080199_mem_arb.sv
// ysyx_25080199_mem_arb: round-robin IFU/LSU arbiter sequencing one memory transaction at a time
module ysyx_25080199_mem_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_wen,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic [31:0] ls_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e      state_q, state_d;
  logic        owner_q, last_q;
  logic [31:0] addr_q, wdata_q;
  logic        wen_q;
  logic [3:0]  wmask_q;
  logic [7:0]  cnt_q;
  logic        if_win, ls_win, accept, tmo, done;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // arbitration and next-state; owner/last_grant encode LS as 1
  always_comb begin
    if_win  = if_req_valid && (!ls_req_valid || last_q);
    ls_win  = ls_req_valid && !if_win;
    accept  = state_q == IDLE && (if_win || ls_win);
    tmo     = state_q == RESP && !mem_resp_valid && cnt_q == 8'(TIMEOUT - 1);
    state_d = state_q == IDLE ? (accept ? REQ : IDLE) :
              state_q == REQ  ? (mem_req_ready ? RESP : REQ) :
              (mem_resp_valid || tmo) ? IDLE : RESP;
  end
  // request latch, grant history and RESP timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        owner_q <= ls_win;
        last_q  <= ls_win;
        addr_q  <= ls_win ? ls_addr : if_addr;
        wen_q   <= ls_win && ls_wen;
        wdata_q <= ls_win ? ls_wdata : '0;
        wmask_q <= ls_win ? ls_wmask : '0;
      end
      if (state_q == REQ)       cnt_q <= '0;
      else if (state_q == RESP) cnt_q <= cnt_q + 8'd1;
    end
  end
  // outputs; handshakes and pulses are held low while reset is asserted
  always_comb begin
    done          = rst_n && state_q == RESP && (mem_resp_valid || tmo);
    if_req_ready  = rst_n && state_q == IDLE && if_win;
    ls_req_ready  = rst_n && state_q == IDLE && ls_win;
    if_resp_valid = done && !owner_q;
    ls_resp_valid = done && owner_q;
    if_rdata      = if_resp_valid && mem_resp_valid ? mem_rdata : '0;
    ls_rdata      = ls_resp_valid && mem_resp_valid ? mem_rdata : '0;
    resp_err      = done && !mem_resp_valid;
    mem_req_valid = rst_n && state_q == REQ;
    busy          = rst_n && state_q != IDLE;
    mem_addr      = addr_q;
    mem_wen       = wen_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
  end
endmodule

// File: tb/tb_ysyx_25080199_mem_arb.sv
// tb_ysyx_25080199_mem_arb: directed cycle vectors plus a hand-written stalled-store sequence
module tb_ysyx_25080199_mem_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid;
  logic [31:0] if_addr = 32'h8000_0000, if_rdata;
  logic        ls_req_valid = 1'b0, ls_req_ready, ls_wen = 1'b1, ls_resp_valid;
  logic [31:0] ls_addr = 32'h8000_1000, ls_wdata = 32'hDEAD_BEEF, ls_rdata;
  logic [3:0]  ls_wmask = 4'b1111;
  logic        resp_err, mem_req_valid, mem_req_ready = 1'b0, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0, busy;
  int          checks = 0, errors = 0;

  ysyx_25080199_mem_arb #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // fl = {if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, resp_err, busy}
  typedef struct {
    logic rst, ifv, lsv, mrr, mrv;
    logic [31:0] mrd;
    logic [6:0] fl;
    logic [31:0] ifd, lsd, ma;
    logic mw;
  } vec_t;
  vec_t q[$];

  task automatic add(input logic rst, ifv, lsv, mrr, mrv, input logic [31:0] mrd,
                     input logic [6:0] fl, input logic [31:0] ifd, lsd, ma, input logic mw);
    vec_t v;
    v.rst = rst; v.ifv = ifv; v.lsv = lsv; v.mrr = mrr; v.mrv = mrv; v.mrd = mrd;
    v.fl = fl; v.ifd = ifd; v.lsd = lsd; v.ma = ma; v.mw = mw;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic found;
    // single fetch, spurious idle response
    add(1,1,0,0,0,32'h0,        7'b1000000, 0, 0, 32'h0,         0);
    add(1,0,0,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_0000, 0);
    add(1,0,0,0,1,32'h413,      7'b0001001, 32'h413, 0, 32'h8000_0000, 0);
    add(1,0,0,0,1,32'h1234,     7'b0000000, 0, 0, 32'h8000_0000, 0);
    // both valid: LS then IF, IF stalled 5 cycles
    add(1,1,1,0,0,32'h0,        7'b0100000, 0, 0, 32'h8000_0000, 0);
    add(1,1,1,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_1000, 1);
    add(1,1,1,0,1,32'hABCD,     7'b0000101, 0, 32'hABCD, 32'h8000_1000, 1);
    add(1,1,1,0,0,32'h0,        7'b1000000, 0, 0, 32'h8000_1000, 1);
    for (int i = 0; i < 5; i++)
      add(1,1,1,0,0,32'h0,      7'b0010001, 0, 0, 32'h8000_0000, 0);
    add(1,1,1,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_0000, 0);
    add(1,1,1,0,1,32'hCAFEF00D, 7'b0001001, 32'hCAFEF00D, 0, 32'h8000_0000, 0);
    // LS grant then timeout in the 4th RESP cycle
    add(1,1,1,0,0,32'h0,        7'b0100000, 0, 0, 32'h8000_0000, 0);
    add(1,0,0,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_1000, 1);
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,32'h0,      7'b0000001, 0, 0, 32'h8000_1000, 1);
    add(1,0,0,0,0,32'hFFFFFFFF, 7'b0000111, 0, 0, 32'h8000_1000, 1);
    add(1,0,0,0,0,32'h0,        7'b0000000, 0, 0, 32'h8000_1000, 1);
    // response arriving exactly on the timeout cycle wins
    add(1,1,0,0,0,32'h0,        7'b1000000, 0, 0, 32'h8000_1000, 1);
    add(1,0,0,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_0000, 0);
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,32'h0,      7'b0000001, 0, 0, 32'h8000_0000, 0);
    add(1,0,0,0,1,32'h11111111, 7'b0001001, 32'h11111111, 0, 32'h8000_0000, 0);
    // reset while in RESP drops the transaction, IF wins the next tie
    add(1,1,0,0,0,32'h0,        7'b1000000, 0, 0, 32'h8000_0000, 0);
    add(1,0,0,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_0000, 0);
    add(0,0,0,0,1,32'h5,        7'b0000000, 0, 0, 32'h8000_0000, 0);
    add(1,1,1,0,0,32'h0,        7'b1000000, 0, 0, 32'h0,         0);
    add(1,0,0,1,0,32'h0,        7'b0010001, 0, 0, 32'h8000_0000, 0);
    add(1,0,0,0,1,32'h22,       7'b0001001, 32'h22, 0, 32'h8000_0000, 0);
    add(1,0,0,0,0,32'h0,        7'b0000000, 0, 0, 32'h8000_0000, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_req_valid", mem_req_valid, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wmask", mem_wmask, 0);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst_n = q[i].rst; if_req_valid = q[i].ifv; ls_req_valid = q[i].lsv;
      mem_req_ready = q[i].mrr; mem_resp_valid = q[i].mrv; mem_rdata = q[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_flags", i),
          {25'd0, if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid, ls_resp_valid, resp_err, busy},
          {25'd0, q[i].fl});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, q[i].ma);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, q[i].mw);
      chk($sformatf("v%0d_mem_wmask", i), mem_wmask, q[i].mw ? 4'hF : 4'h0);
      if (q[i].mw) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      if (q[i].fl[3]) chk($sformatf("v%0d_if_rdata", i), if_rdata, q[i].ifd);
      if (q[i].fl[2]) chk($sformatf("v%0d_ls_rdata", i), ls_rdata, q[i].lsd);
    end

    // stalled store from LSU: fields stay stable, valid dropped after acceptance
    @(posedge clk);
    #1;
    if_req_valid = 1; ls_req_valid = 1; ls_addr = 32'h8000_2000;
    ls_wdata = 32'h1234_5678; ls_wmask = 4'b0101;
    @(negedge clk);
    chk("st_ls_ready", ls_req_ready, 1);
    chk("st_if_ready", if_req_ready, 0);
    @(posedge clk);
    #1;
    if_req_valid = 0; ls_req_valid = 0; ls_wdata = 32'h0; ls_wmask = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("st_mem_req_valid", mem_req_valid, 1);
      chk("st_mem_addr", mem_addr, 32'h8000_2000);
      chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("st_mem_wmask", mem_wmask, 4'b0101);
      @(posedge clk);
      #1;
    end
    mem_req_ready = 1;
    @(posedge clk);
    #1;
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hA5A5_A5A5;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (ls_resp_valid) begin
        found = 1;
        chk("st_ls_rdata", ls_rdata, 32'hA5A5_A5A5);
        chk("st_resp_err", resp_err, 0);
        chk("st_if_resp_valid", if_resp_valid, 0);
      end
    end
    chk("st_ls_resp_seen", found, 1);
    @(posedge clk);
    #1;
    mem_resp_valid = 0;
    @(negedge clk);
    chk("st_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
